sleep_controller: RTL and testbench
===================================

// Module: sleep_controller
// PURPOSE
//  Stateful sleep/wake arbiter for the mimosa core. It owns the asleep state itself instead of reading it back from action.
//  Adds drowsy-entry timing, a minimum sleep time, wake debounce and parametrised widths/thresholds.
//  Sits between the neurotransmitter/vital-energy blocks and the action selector.
//  Emits one-cycle sleep_in/wake_up pulses and a level is_asleep.
// PARAMETERS
//  NT_W            2        width of each of the 5 neurotransmitter fields
//  ENERGY_W        2        width of vital_energy_level
//  CNT_W           8        width of drowsy/sleep/debounce counters (all saturating)
//  DROWSY_CYCLES   8        consecutive calm+low-energy cycles before falling asleep (1..2^CNT_W-1)
//  MIN_SLEEP_CYCLES 16      arousal ignored until this many cycles asleep
//  WAKE_DEBOUNCE   4        consecutive aroused cycles needed to wake (>=1)
//  DISTURB_MASK    16'h1547 stimuli bits that disturb (tickle,play,talk,hot,loud,bright,starving)
//  MAX_SLEEP_CYCLES 200     forced-wake limit (used only with SLEEP_MAX_DURATION_EN)
// PORTS
//  clk                     in   1          system clock
//  rst                     in   1          synchronous reset, active-high
//  neurotransmitter_level  in   5*NT_W     {SER,NE,GABA,DOP,CORT}; CORT in the LSB field
//  stimuli                 in   16         stimulus vector
//  vital_energy_level      in   ENERGY_W   quantised energy
//  vital_energy_zero       in   1          energy exhausted
//  sleep_in_signal         out  1          1-cycle pulse on entry to ASLEEP
//  wake_up_signal          out  1          1-cycle pulse on entry to AWAKE from ASLEEP/WAKING
//  is_asleep               out  1          high in ASLEEP or WAKING
//  sleep_state             out  2          current FSM state
// BEHAVIOUR
//  Derived signals (combinational):
//   high(x) = MSB of the field; disturb = |(stimuli & DISTURB_MASK).
//   calm    = !high(NE) & !high(CORT) & !disturb.
//   low     = (vital_energy_level==0); full = &vital_energy_level.
//   aroused = (vital_energy_level!=0) & (high(NE)|high(CORT)|disturb).
//  States: AWAKE=0, DROWSY=1, ASLEEP=2, WAKING=3. Reset -> AWAKE; all counters 0; all outputs 0.
//  AWAKE:  vital_energy_zero -> ASLEEP + sleep_in pulse.
//          else low&calm -> DROWSY, drowsy_cnt=0.
//  DROWSY: vital_energy_zero -> ASLEEP + pulse.
//          else !(low&calm) -> AWAKE, no pulse.
//          else drowsy_cnt==DROWSY_CYCLES-1 -> ASLEEP + pulse; else drowsy_cnt++.
//  On ASLEEP entry: sleep_cnt=0.
//  ASLEEP: sleep_cnt++ each cycle, saturating at all-ones.
//          Priority: vital_energy_zero holds ASLEEP; full -> AWAKE + wake_up pulse;
//          aroused & sleep_cnt>=MIN_SLEEP_CYCLES -> WAKING, deb_cnt=0.
//  WAKING: sleep_cnt keeps counting.
//          vital_energy_zero or !aroused -> ASLEEP; sleep_cnt retained, no pulse.
//          full -> AWAKE + pulse.
//          deb_cnt==WAKE_DEBOUNCE-1 -> AWAKE + pulse; else deb_cnt++.
//  vital_energy_zero and full both high (ENERGY_W mismatch upstream): zero wins.
//  Pulses are registered and asserted in the first cycle sleep_state shows the new state; never high together.
//  A pulse is never asserted for transitions that return to the same sleep/awake class.
//  is_asleep and sleep_state are registered (decode of the state register).
//  rst mid-sleep -> AWAKE next edge with no wake_up pulse.
//  Inputs are sampled every cycle; no handshake; latency 1 cycle from qualifying input to pulse.
// CONFIGURATION
//  SLEEP_MAX_DURATION_EN defined: in ASLEEP/WAKING, sleep_cnt==MAX_SLEEP_CYCLES forces AWAKE + wake_up pulse.
//   Lower priority than vital_energy_zero; higher than debounce.
//  Not defined: no forced wake; sleep_cnt saturates; MAX_SLEEP_CYCLES is ignored.
// STRUCTURE
//  sleep_pkg.vh: state encodings, NT field indices (CORT=0,DOP=1,GABA=2,NE=3,SER=4),
//   default DISTURB_MASK, stimulus bit indices.
//  Sub-module sleep_sat_counter (CNT_W, clear, enable, count, at_max); three instances:
//   drowsy, sleep, debounce.
//  FSM and pulse registers stay in sleep_controller.
// TESTING
//  Defaults. energy=0, NE=CORT=1, stimuli=0 held -> DROWSY, then sleep_in_signal high exactly 9 cycles later,
//   once; is_asleep=1.
//  Same, stimuli[0]=1 at drowsy cycle 4 -> back to AWAKE, no pulse; re-entry restarts the count.
//  Asleep, energy=1, NE=2'b10 at sleep_cnt=5 -> no wake until sleep_cnt=16;
//   then WAKING, wake_up_signal 4 cycles later.
//  WAKING with arousal dropping after 2 cycles -> ASLEEP, no pulse; sleep_cnt continues from its value.
//  Asleep at sleep_cnt=3, energy=2'b11 -> wake_up_signal next cycle, min sleep bypassed.
//   With vital_energy_zero=1 also high -> stays asleep.
//  With SLEEP_MAX_DURATION_EN, MAX=20, no arousal -> wake_up_signal at sleep_cnt=20.
//   Without the macro -> asleep indefinitely. rst asserted mid-sleep -> AWAKE, outputs 0.

Source files
------------

// File: rtl/sleep_pkg.sv
// Shared encodings for the sleep/wake arbiter: FSM states, neurotransmitter
// field indices and stimulus bit positions.
package sleep_pkg;

   localparam logic [1:0] ST_AWAKE  = 2'd0;
   localparam logic [1:0] ST_DROWSY = 2'd1;
   localparam logic [1:0] ST_ASLEEP = 2'd2;
   localparam logic [1:0] ST_WAKING = 2'd3;

   // Field order in neurotransmitter_level is {SER,NE,GABA,DOP,CORT}
   localparam int unsigned NT_CORT = 0;
   localparam int unsigned NT_DOP  = 1;
   localparam int unsigned NT_GABA = 2;
   localparam int unsigned NT_NE   = 3;
   localparam int unsigned NT_SER  = 4;

   localparam int unsigned STIM_TICKLE   = 0;
   localparam int unsigned STIM_PLAY     = 1;
   localparam int unsigned STIM_TALK     = 2;
   localparam int unsigned STIM_HOT      = 6;
   localparam int unsigned STIM_LOUD     = 8;
   localparam int unsigned STIM_BRIGHT   = 10;
   localparam int unsigned STIM_STARVING = 12;

   localparam logic [15:0] DISTURB_MASK_DEFAULT =
      (16'd1 << STIM_TICKLE) | (16'd1 << STIM_PLAY)   | (16'd1 << STIM_TALK) |
      (16'd1 << STIM_HOT)    | (16'd1 << STIM_LOUD)   | (16'd1 << STIM_BRIGHT) |
      (16'd1 << STIM_STARVING);

   // ASLEEP and WAKING both count as the sleep class
   function automatic logic in_sleep_class(input logic [1:0] st);
      return st[1];
   endfunction

endpackage

// File: rtl/sleep_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sleep_sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   assign at_max = &count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !at_max) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sleep_controller.sv
// Sleep/wake arbiter FSM with drowsy entry, minimum sleep and wake debounce.
// Optional forced wake after a maximum sleep time: SLEEP_MAX_DURATION_EN.
module sleep_controller
   import sleep_pkg::*;
#(
   parameter int unsigned NT_W             = 2,
   parameter int unsigned ENERGY_W         = 2,
   parameter int unsigned CNT_W            = 8,
   parameter int unsigned DROWSY_CYCLES    = 8,
   parameter int unsigned MIN_SLEEP_CYCLES = 16,
   parameter int unsigned WAKE_DEBOUNCE    = 4,
   parameter logic [15:0] DISTURB_MASK     = DISTURB_MASK_DEFAULT,
   parameter int unsigned MAX_SLEEP_CYCLES = 200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5*NT_W-1:0]   neurotransmitter_level,
   input  logic [15:0]         stimuli,
   input  logic [ENERGY_W-1:0] vital_energy_level,
   input  logic                vital_energy_zero,
   output logic                sleep_in_signal,
   output logic                wake_up_signal,
   output logic                is_asleep,
   output logic [1:0]          sleep_state
);

   logic [1:0]      state, state_nxt;
   logic [NT_W-1:0] f_ser, f_ne, f_gaba, f_dop, f_cort;
   logic            disturb, calm, low, full, aroused;
   logic [CNT_W-1:0] drowsy_cnt, sleep_cnt, deb_cnt;
   logic            drowsy_done, slept_min, deb_done, force_wake;
   logic            unused_nt;
   logic [2:0]      unused_at_max;

   assign f_ser  = neurotransmitter_level[NT_SER*NT_W  +: NT_W];
   assign f_ne   = neurotransmitter_level[NT_NE*NT_W   +: NT_W];
   assign f_gaba = neurotransmitter_level[NT_GABA*NT_W +: NT_W];
   assign f_dop  = neurotransmitter_level[NT_DOP*NT_W  +: NT_W];
   assign f_cort = neurotransmitter_level[NT_CORT*NT_W +: NT_W];
   assign unused_nt = ^{f_ser, f_gaba, f_dop, f_ne, f_cort};

   assign disturb = |(stimuli & DISTURB_MASK);
   assign calm    = !f_ne[NT_W-1] && !f_cort[NT_W-1] && !disturb;
   assign low     = (vital_energy_level == '0);
   assign full    = &vital_energy_level;
   assign aroused = !low && (f_ne[NT_W-1] || f_cort[NT_W-1] || disturb);

   assign drowsy_done = (drowsy_cnt == CNT_W'(DROWSY_CYCLES - 1));
   assign slept_min   = (sleep_cnt >= CNT_W'(MIN_SLEEP_CYCLES));
   assign deb_done    = (deb_cnt == CNT_W'(WAKE_DEBOUNCE - 1));

`ifdef SLEEP_MAX_DURATION_EN
   assign force_wake = (sleep_cnt == CNT_W'(MAX_SLEEP_CYCLES));
`else
   logic unused_max;
   assign unused_max = (sleep_cnt == CNT_W'(MAX_SLEEP_CYCLES));
   assign force_wake = 1'b0;
`endif

   // Each counter is held clear outside its own state, so it reads 0 on entry
   sleep_sat_counter #(.CNT_W(CNT_W)) u_drowsy_cnt (
      .clk(clk), .rst(rst),
      .clear(state != ST_DROWSY), .enable(state == ST_DROWSY),
      .count(drowsy_cnt), .at_max(unused_at_max[0])
   );

   sleep_sat_counter #(.CNT_W(CNT_W)) u_sleep_cnt (
      .clk(clk), .rst(rst),
      .clear(!in_sleep_class(state)), .enable(in_sleep_class(state)),
      .count(sleep_cnt), .at_max(unused_at_max[1])
   );

   sleep_sat_counter #(.CNT_W(CNT_W)) u_deb_cnt (
      .clk(clk), .rst(rst),
      .clear(state != ST_WAKING), .enable(state == ST_WAKING),
      .count(deb_cnt), .at_max(unused_at_max[2])
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_AWAKE: begin
            if (vital_energy_zero)  state_nxt = ST_ASLEEP;
            else if (low && calm)   state_nxt = ST_DROWSY;
         end
         ST_DROWSY: begin
            if (vital_energy_zero)     state_nxt = ST_ASLEEP;
            else if (!(low && calm))   state_nxt = ST_AWAKE;
            else if (drowsy_done)      state_nxt = ST_ASLEEP;
         end
         ST_ASLEEP: begin
            if (vital_energy_zero)            state_nxt = ST_ASLEEP;
            else if (force_wake)              state_nxt = ST_AWAKE;
            else if (full)                    state_nxt = ST_AWAKE;
            else if (aroused && slept_min)    state_nxt = ST_WAKING;
         end
         ST_WAKING: begin
            if (vital_energy_zero)  state_nxt = ST_ASLEEP;
            else if (force_wake)    state_nxt = ST_AWAKE;
            else if (!aroused)      state_nxt = ST_ASLEEP;
            else if (full)          state_nxt = ST_AWAKE;
            else if (deb_done)      state_nxt = ST_AWAKE;
         end
         default: state_nxt = ST_AWAKE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_AWAKE;
         sleep_in_signal <= 1'b0;
         wake_up_signal  <= 1'b0;
      end else begin
         state           <= state_nxt;
         sleep_in_signal <= !in_sleep_class(state) && in_sleep_class(state_nxt);
         wake_up_signal  <= in_sleep_class(state) && (state_nxt == ST_AWAKE);
      end
   end

   assign is_asleep   = in_sleep_class(state);
   assign sleep_state = state;

endmodule

// File: tb/tb_sleep_controller.sv
// Directed self-checking bench for sleep_controller (defaults, MAX_SLEEP_CYCLES=20).
module tb_sleep_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] nt;
   logic [15:0] stim;
   logic [1:0] energy;
   logic       ezero;
   logic       sleep_in_signal, wake_up_signal, is_asleep;
   logic [1:0] sleep_state;

   int total = 0;
   int bad   = 0;
   int first, pulses, first_wk, first_wu, wu;

   // {SER,NE,GABA,DOP,CORT}
   localparam logic [9:0] NT_CALM  = 10'b00_01_00_00_01;
   localparam logic [9:0] NT_NE_HI = 10'b00_10_00_00_01;

   always #5 clk = ~clk;

   sleep_controller #(.MAX_SLEEP_CYCLES(20)) dut (
      .clk(clk),
      .rst(rst),
      .neurotransmitter_level(nt),
      .stimuli(stim),
      .vital_energy_level(energy),
      .vital_energy_zero(ezero),
      .sleep_in_signal(sleep_in_signal),
      .wake_up_signal(wake_up_signal),
      .is_asleep(is_asleep),
      .sleep_state(sleep_state)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // From AWAKE with energy=0 and calm: pulse lands 9 edges after the inputs
   task automatic go_sleep(input string tag);
      int f;
      f = 0;
      energy = 2'd0;
      nt     = NT_CALM;
      stim   = 16'h0;
      ezero  = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (sleep_in_signal) begin
            f = i;
            break;
         end
      end
      chk(tag, f, 9);
   endtask

   initial begin
      rst = 1'b1; nt = NT_CALM; stim = 16'h0; energy = 2'd2; ezero = 1'b0;
      tick(); tick();
      chk("rst_state", sleep_state, 0);
      chk("rst_is_asleep", is_asleep, 0);
      chk("rst_sleep_in", sleep_in_signal, 0);
      chk("rst_wake_up", wake_up_signal, 0);
      rst = 1'b0;
      tick();
      chk("idle_awake", sleep_state, 0);

      // Drowsy entry then sleep
      energy = 2'd0; first = 0; pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 1) chk("drowsy_entry", sleep_state, 1);
         if (sleep_in_signal) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      chk("sleep_latency", first, 9);
      chk("sleep_pulse_once", pulses, 1);
      chk("asleep_level", is_asleep, 1);
      chk("asleep_state", sleep_state, 2);

      // sleep_cnt=3: full energy with zero also high stays asleep, then full wakes
      energy = 2'd3; ezero = 1'b1;
      tick();
      chk("zero_wins_state", sleep_state, 2);
      chk("zero_wins_wake", wake_up_signal, 0);
      ezero = 1'b0;
      tick();
      chk("full_wake_pulse", wake_up_signal, 1);
      chk("full_wake_state", sleep_state, 0);
      chk("full_wake_level", is_asleep, 0);
      tick();
      chk("wake_one_shot", wake_up_signal, 0);

      // Drowsy interrupted by a tickle at drowsy cycle 4
      energy = 2'd0;
      for (int i = 1; i <= 4; i++) tick();
      chk("drowsy_hold", sleep_state, 1);
      stim = 16'h0001;
      tick();
      chk("disturb_abort_state", sleep_state, 0);
      chk("disturb_abort_pulse", sleep_in_signal, 0);
      stim = 16'h0;
      first = 0; pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (sleep_in_signal) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      chk("reentry_latency", first, 9);
      chk("reentry_pulse_once", pulses, 1);

      // Arousal at sleep_cnt=5 must wait for the minimum sleep time
      tick(); tick();
      energy = 2'd1; nt = NT_NE_HI;
      first_wk = 0; first_wu = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (sleep_state == 2'd3 && first_wk == 0) first_wk = i;
         if (wake_up_signal && first_wu == 0) first_wu = i;
      end
      chk("min_sleep_waking", first_wk, 12);
      chk("debounce_wake_at", first_wu, 16);
      chk("debounce_awake", sleep_state, 0);

      // WAKING abandoned after 2 cycles keeps sleep_cnt, so re-arousal is immediate
      go_sleep("resleep1");
      repeat (16) tick();
      energy = 2'd1; nt = NT_NE_HI;
      tick();
      chk("waking_entry", sleep_state, 3);
      tick();
      chk("waking_hold", sleep_state, 3);
      nt = NT_CALM;
      tick();
      chk("arousal_drop_state", sleep_state, 2);
      chk("arousal_drop_wake", wake_up_signal, 0);
      chk("arousal_drop_sleep", sleep_in_signal, 0);
      nt = NT_NE_HI;
      tick();
      chk("cnt_retained", sleep_state, 3);
      repeat (3) tick();
      chk("debounce_restart", sleep_state, 3);
      tick();
      chk("rewake_pulse", wake_up_signal, 1);

      nt = NT_CALM;
      go_sleep("resleep2");
`ifdef SLEEP_MAX_DURATION_EN
      first = 0;
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (wake_up_signal && first == 0) first = i;
      end
      chk("max_wake_at", first, 21);
      energy = 2'd2;
      tick();
      chk("max_then_awake", sleep_state, 0);
      go_sleep("resleep3");
`else
      wu = 0;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (wake_up_signal) wu++;
      end
      chk("no_max_wake", wu, 0);
      chk("sleep_saturate", sleep_state, 2);
`endif

      // Reset mid-sleep
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("midrst_state", sleep_state, 0);
      chk("midrst_level", is_asleep, 0);
      chk("midrst_wake", wake_up_signal, 0);
      chk("midrst_sleep", sleep_in_signal, 0);
      rst = 1'b0; energy = 2'd2;
      tick();
      chk("post_rst_wake", wake_up_signal, 0);
      chk("post_rst_state", sleep_state, 0);

      // Energy exhausted from AWAKE sleeps directly
      ezero = 1'b1;
      tick();
      chk("zero_sleep_state", sleep_state, 2);
      chk("zero_sleep_pulse", sleep_in_signal, 1);
      tick();
      chk("zero_sleep_one_shot", sleep_in_signal, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
